// File: rtl/int32_pkg.sv
// Shared types for the int32 dispatch slice: instruction/tag records,
// exception codes and the legal-opcode screen.
package int32_pkg;
   localparam int unsigned INT32_DATA_W = 32;
   localparam int unsigned INT32_OPC_W  = 8;
   localparam int unsigned INT32_REG_W  = 5;

   localparam logic [INT32_OPC_W-1:0] OP_ADD  = 8'h01;
   localparam logic [INT32_OPC_W-1:0] OP_SUB  = 8'h02;
   localparam logic [INT32_OPC_W-1:0] OP_MUL  = 8'h03;
   localparam logic [INT32_OPC_W-1:0] OP_DIV  = 8'h04;
   localparam logic [INT32_OPC_W-1:0] OP_AND  = 8'h20;
   localparam logic [INT32_OPC_W-1:0] OP_ADDC = 8'h90;

   typedef enum logic [1:0] {
      EXC_NONE    = 2'b00,
      EXC_ILLEGAL = 2'b01,
      EXC_DIV0    = 2'b10
   } exc_code_t;

   typedef struct packed {
      logic [INT32_OPC_W-1:0]  opcode;
      logic [INT32_REG_W-1:0]  rd;
      logic [INT32_DATA_W-1:0] rs1_val;
      logic [INT32_DATA_W-1:0] rs2_val;
      logic                    use_imm;
      logic [INT32_DATA_W-1:0] imm;
   } instr_t;

   typedef struct packed {
      logic                   valid;
      logic [INT32_REG_W-1:0] rd;
   } tag_t;

   function automatic logic is_legal_opcode(input logic [INT32_OPC_W-1:0] op);
      return op inside {[8'h01:8'h06], [8'h20:8'h24], [8'h30:8'h33], [8'h40:8'h49],
                        [8'h60:8'h63], [8'h70:8'h73], [8'h80:8'h81], [8'h90:8'h92]};
   endfunction
endpackage

// File: rtl/int32_dispatch_fifo.sv
// Instruction buffer: synchronous FIFO of instr_t with occupancy count.
// Caller must not push when full or pop when empty.
module int32_dispatch_fifo
   import int32_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  instr_t        wr_data,
   output instr_t        rd_data,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);
   instr_t        mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   // Power-of-two depth lets the pointers wrap by natural overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = mem[rd_ptr];
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
endmodule

// File: rtl/int32_dispatch.sv
// Dispatch unit for the int32 core: buffers instructions, screens illegal
// opcodes and divide-by-zero, issues one per cycle and pairs results with rd.
module int32_dispatch
   import int32_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned OPCODE_WIDTH   = 8,
   parameter int unsigned REG_ADDR_WIDTH = 5,
   parameter int unsigned FIFO_DEPTH     = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [OPCODE_WIDTH-1:0]       in_opcode,
   input  logic [REG_ADDR_WIDTH-1:0]     in_rd,
   input  logic [DATA_WIDTH-1:0]         in_rs1_val,
   input  logic [DATA_WIDTH-1:0]         in_rs2_val,
   input  logic                          in_use_imm,
   input  logic [DATA_WIDTH-1:0]         in_imm,
   input  logic                          issue_hold,
   output logic                          core_valid_instruction,
   output logic [OPCODE_WIDTH-1:0]       core_opcode,
   output logic [DATA_WIDTH-1:0]         core_operand_a,
   output logic [DATA_WIDTH-1:0]         core_operand_b,
   output logic                          core_use_immediate,
   output logic [DATA_WIDTH-1:0]         core_immediate_value,
   input  logic                          core_result_valid,
   input  logic [DATA_WIDTH-1:0]         core_result_out,
   input  logic                          core_carry_out,
   input  logic                          core_overflow_out,
   output logic                          wb_valid,
   output logic [REG_ADDR_WIDTH-1:0]     wb_rd,
   output logic [DATA_WIDTH-1:0]         wb_data,
   output logic                          wb_carry,
   output logic                          wb_overflow,
   output logic                          exc_valid,
   output logic [1:0]                    exc_code,
   output logic [REG_ADDR_WIDTH-1:0]     exc_rd,
   output logic                          resp_err,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
   instr_t                in_entry;
   instr_t                head;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  push;
   logic                  pop;
   logic [DATA_WIDTH-1:0] eff_b;
   logic                  legal;
   logic                  div0;
   tag_t                  issue_tag;
   tag_t                  pend;
   exc_code_t             exc_code_q;

   assign in_entry = '{opcode: in_opcode, rd: in_rd, rs1_val: in_rs1_val,
                       rs2_val: in_rs2_val, use_imm: in_use_imm, imm: in_imm};

   // in_ready ignores a same-cycle pop so a full buffer always refuses.
   assign in_ready = !fifo_full;
   assign push     = in_valid && !fifo_full;
   assign pop      = !fifo_empty && !issue_hold;

   int32_dispatch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .pop     (pop),
      .wr_data (in_entry),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   always_comb begin
      eff_b = head.use_imm ? head.imm : head.rs2_val;
      legal = is_legal_opcode(head.opcode);
      div0  = (head.opcode == OP_DIV) && (eff_b == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         core_valid_instruction <= 1'b0;
         core_opcode            <= '0;
         core_operand_a         <= '0;
         core_operand_b         <= '0;
         core_use_immediate     <= 1'b0;
         core_immediate_value   <= '0;
         issue_tag              <= '0;
         pend                   <= '0;
         exc_valid              <= 1'b0;
         exc_code_q             <= EXC_NONE;
         exc_rd                 <= '0;
         wb_valid               <= 1'b0;
         wb_rd                  <= '0;
         wb_data                <= '0;
         wb_carry               <= 1'b0;
         wb_overflow            <= 1'b0;
         resp_err               <= 1'b0;
      end else begin
         core_valid_instruction <= 1'b0;
         issue_tag              <= '0;
         exc_valid              <= 1'b0;
         exc_code_q             <= EXC_NONE;
         exc_rd                 <= '0;
         if (pop) begin
            if (!legal) begin
               exc_valid  <= 1'b1;
               exc_code_q <= EXC_ILLEGAL;
               exc_rd     <= head.rd;
            end else if (div0) begin
               exc_valid  <= 1'b1;
               exc_code_q <= EXC_DIV0;
               exc_rd     <= head.rd;
            end else begin
               core_valid_instruction <= 1'b1;
               core_opcode            <= head.opcode;
               core_operand_a         <= head.rs1_val;
               core_operand_b         <= head.rs2_val;
               core_use_immediate     <= head.use_imm;
               core_immediate_value   <= head.imm;
               issue_tag              <= '{valid: 1'b1, rd: head.rd};
            end
         end

         // Core answers exactly one cycle after issue; pend lines up with it.
         pend <= issue_tag;
         if (pend.valid && core_result_valid) begin
            wb_valid    <= 1'b1;
            wb_rd       <= pend.rd;
            wb_data     <= core_result_out;
            wb_carry    <= core_carry_out;
            wb_overflow <= core_overflow_out;
         end else begin
            wb_valid    <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            wb_carry    <= 1'b0;
            wb_overflow <= 1'b0;
         end
         if (pend.valid != core_result_valid) resp_err <= 1'b1;
      end
   end

   assign exc_code = exc_code_q;
endmodule

// File: tb/tb_int32_dispatch.sv
// Directed bench for int32_dispatch with a one-cycle adder standing in for the core.
module tb_int32_dispatch;
   logic        clk, rst;
   logic        in_valid, in_ready;
   logic [7:0]  in_opcode;
   logic [4:0]  in_rd;
   logic [31:0] in_rs1_val, in_rs2_val, in_imm;
   logic        in_use_imm, issue_hold;
   logic        core_valid_instruction;
   logic [7:0]  core_opcode;
   logic [31:0] core_operand_a, core_operand_b, core_immediate_value;
   logic        core_use_immediate;
   logic        core_result_valid, core_carry_out, core_overflow_out;
   logic [31:0] core_result_out;
   logic        wb_valid, wb_carry, wb_overflow;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        exc_valid;
   logic [1:0]  exc_code;
   logic [4:0]  exc_rd;
   logic        resp_err;
   logic [2:0]  fifo_count;

   int checks = 0;
   int errors = 0;
   logic suppress;

   int32_dispatch #(.DATA_WIDTH(32), .OPCODE_WIDTH(8), .REG_ADDR_WIDTH(5), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
      .in_use_imm(in_use_imm), .in_imm(in_imm), .issue_hold(issue_hold),
      .core_valid_instruction(core_valid_instruction), .core_opcode(core_opcode),
      .core_operand_a(core_operand_a), .core_operand_b(core_operand_b),
      .core_use_immediate(core_use_immediate), .core_immediate_value(core_immediate_value),
      .core_result_valid(core_result_valid), .core_result_out(core_result_out),
      .core_carry_out(core_carry_out), .core_overflow_out(core_overflow_out),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_carry(wb_carry),
      .wb_overflow(wb_overflow), .exc_valid(exc_valid), .exc_code(exc_code), .exc_rd(exc_rd),
      .resp_err(resp_err), .fifo_count(fifo_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Core stand-in: registered 33-bit add of A and the selected B operand.
   logic [31:0] bsel;
   logic [32:0] sum;
   always_comb begin
      bsel = core_use_immediate ? core_immediate_value : core_operand_b;
      sum  = {1'b0, core_operand_a} + {1'b0, bsel};
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         core_result_valid <= 1'b0;
         core_result_out   <= '0;
         core_carry_out    <= 1'b0;
         core_overflow_out <= 1'b0;
      end else begin
         core_result_valid <= core_valid_instruction && !suppress;
         core_result_out   <= sum[31:0];
         core_carry_out    <= sum[32];
         core_overflow_out <= (core_operand_a[31] == bsel[31]) && (sum[31] != core_operand_a[31]);
      end
   end

   task step;
      @(posedge clk);
      #1;
   endtask

   task drive(input logic [7:0] op, input logic [4:0] rd, input logic [31:0] a,
              input logic [31:0] b, input logic ui, input logic [31:0] imm);
      in_valid = 1'b1; in_opcode = op; in_rd = rd;
      in_rs1_val = a; in_rs2_val = b; in_use_imm = ui; in_imm = imm;
   endtask

   task test_reset;
      #2;
      checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
      checks++; if ({core_valid_instruction, wb_valid, exc_valid, resp_err} !== 4'b0000) begin errors++; $display("FAIL reset_strobes got %b exp 0000", {core_valid_instruction, wb_valid, exc_valid, resp_err}); end
      checks++; if ({core_opcode, core_operand_a, wb_data, wb_rd, exc_code} !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", {core_opcode, core_operand_a, wb_data, wb_rd, exc_code}); end
      step; step;
      rst = 1'b0;
      step;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", in_ready); end
   endtask

   task test_single_add;
      drive(8'h01, 5'd3, 32'd5, 32'd7, 1'b0, 32'd0);
      step; in_valid = 1'b0;
      checks++; if (fifo_count !== 3'd1 || core_valid_instruction !== 1'b0) begin errors++; $display("FAIL add_push count %0d valid %b exp 1 0", fifo_count, core_valid_instruction); end
      step;
      checks++; if (core_valid_instruction !== 1'b1 || core_opcode !== 8'h01) begin errors++; $display("FAIL add_issue valid %b op %h exp 1 01", core_valid_instruction, core_opcode); end
      checks++; if (core_operand_a !== 32'd5 || core_operand_b !== 32'd7) begin errors++; $display("FAIL add_operands got %h %h exp 5 7", core_operand_a, core_operand_b); end
      step;
      checks++; if (wb_valid !== 1'b0 || core_valid_instruction !== 1'b0) begin errors++; $display("FAIL add_gap wb %b valid %b exp 0 0", wb_valid, core_valid_instruction); end
      step;
      checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd3 || wb_data !== 32'd12) begin errors++; $display("FAIL add_wb got v%b rd%0d d%h exp v1 rd3 dc", wb_valid, wb_rd, wb_data); end
      step;
      checks++; if (wb_valid !== 1'b0 || resp_err !== 1'b0) begin errors++; $display("FAIL add_after wb %b err %b exp 0 0", wb_valid, resp_err); end
   endtask

   task test_back_to_back;
      logic [7:0]  ops [4];
      logic [31:0] av [4], bv [4], iv [4], dexp [4];
      logic        uv [4], cexp [4];
      ops = '{8'h01, 8'h20, 8'h90, 8'h92};
      av  = '{32'd1, 32'd10, 32'hFFFF_FFFF, 32'h23};
      bv  = '{32'd2, 32'd20, 32'd1, 32'd7};
      uv  = '{1'b0, 1'b0, 1'b0, 1'b1};
      iv  = '{32'd0, 32'd0, 32'd0, 32'h100};
      dexp = '{32'd3, 32'd30, 32'd0, 32'h123};
      cexp = '{1'b0, 1'b0, 1'b1, 1'b0};
      for (int cyc = 0; cyc < 8; cyc++) begin
         if (cyc < 4) drive(ops[cyc], 5'(cyc + 1), av[cyc], bv[cyc], uv[cyc], iv[cyc]);
         else in_valid = 1'b0;
         step;
         if (cyc >= 3 && cyc <= 6) begin
            checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'(cyc - 2) || wb_data !== dexp[cyc-3] || wb_carry !== cexp[cyc-3]) begin
               errors++; $display("FAIL b2b_wb%0d got v%b rd%0d d%h c%b exp v1 rd%0d d%h c%b", cyc - 3, wb_valid, wb_rd, wb_data, wb_carry, cyc - 2, dexp[cyc-3], cexp[cyc-3]);
            end
         end else begin
            checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle%0d wb %b exp 0", cyc, wb_valid); end
         end
      end
   endtask

   task test_full_hold;
      int  wb_seen;
      int  first_wb;
      logic acc;
      issue_hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(8'h01, 5'(11 + i), 32'(i), 32'd100, 1'b0, 32'd0);
         step;
      end
      checks++; if (fifo_count !== 3'd4 || in_ready !== 1'b0) begin errors++; $display("FAIL full_state count %0d ready %b exp 4 0", fifo_count, in_ready); end
      drive(8'h01, 5'd15, 32'd4, 32'd100, 1'b0, 32'd0);
      step; step;
      checks++; if (fifo_count !== 3'd4 || core_valid_instruction !== 1'b0) begin errors++; $display("FAIL full_held count %0d valid %b exp 4 0", fifo_count, core_valid_instruction); end
      issue_hold = 1'b0;
      step;
      checks++; if (fifo_count !== 3'd3 || core_valid_instruction !== 1'b1) begin errors++; $display("FAIL full_pop_refuse count %0d valid %b exp 3 1", fifo_count, core_valid_instruction); end
      wb_seen = 0;
      first_wb = -1;
      for (int c = 0; c < 12; c++) begin
         acc = in_valid && in_ready;
         step;
         if (acc) in_valid = 1'b0;
         if (wb_valid) begin
            if (first_wb < 0) first_wb = c;
            checks++; if (wb_rd !== 5'(11 + wb_seen) || wb_data !== 32'(wb_seen + 100) || c !== first_wb + wb_seen) begin
               errors++; $display("FAIL full_drain%0d got rd%0d d%0d cyc%0d exp rd%0d d%0d cyc%0d", wb_seen, wb_rd, wb_data, c, 11 + wb_seen, wb_seen + 100, first_wb + wb_seen);
            end
            wb_seen++;
         end
      end
      checks++; if (wb_seen !== 5 || in_valid !== 1'b0) begin errors++; $display("FAIL full_total got %0d wbs pending %b exp 5 0", wb_seen, in_valid); end
   endtask

   task test_exceptions;
      drive(8'h07, 5'd9, 32'd1, 32'd1, 1'b0, 32'd0);
      step;
      drive(8'h04, 5'd10, 32'd8, 32'd5, 1'b1, 32'd0);
      step;
      checks++; if (exc_valid !== 1'b1 || exc_code !== 2'b01 || exc_rd !== 5'd9 || core_valid_instruction !== 1'b0) begin errors++; $display("FAIL exc_illegal got v%b c%b rd%0d iss%b exp 1 01 9 0", exc_valid, exc_code, exc_rd, core_valid_instruction); end
      drive(8'h04, 5'd11, 32'd9, 32'd0, 1'b1, 32'd3);
      step; in_valid = 1'b0;
      checks++; if (exc_valid !== 1'b1 || exc_code !== 2'b10 || exc_rd !== 5'd10 || core_valid_instruction !== 1'b0) begin errors++; $display("FAIL exc_div0 got v%b c%b rd%0d iss%b exp 1 10 10 0", exc_valid, exc_code, exc_rd, core_valid_instruction); end
      step;
      checks++; if (exc_valid !== 1'b0 || core_valid_instruction !== 1'b1 || core_operand_b !== 32'd0 || core_use_immediate !== 1'b1 || core_immediate_value !== 32'd3) begin
         errors++; $display("FAIL exc_div_imm got exc%b iss%b b%h ui%b imm%h exp 0 1 0 1 3", exc_valid, core_valid_instruction, core_operand_b, core_use_immediate, core_immediate_value);
      end
      step;
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL exc_no_wb got %b exp 0", wb_valid); end
      step;
      checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd11 || wb_data !== 32'd12 || resp_err !== 1'b0) begin errors++; $display("FAIL exc_div_wb got v%b rd%0d d%0d err%b exp 1 11 12 0", wb_valid, wb_rd, wb_data, resp_err); end
      step;
   endtask

   task test_protocol_err;
      suppress = 1'b1;
      drive(8'h01, 5'd7, 32'd1, 32'd1, 1'b0, 32'd0);
      step; in_valid = 1'b0;
      step; step;
      checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL perr_early got %b exp 0", resp_err); end
      step;
      suppress = 1'b0;
      checks++; if (resp_err !== 1'b1 || wb_valid !== 1'b0) begin errors++; $display("FAIL perr_flag err %b wb %b exp 1 0", resp_err, wb_valid); end
      drive(8'h01, 5'd8, 32'd2, 32'd2, 1'b0, 32'd0);
      step; in_valid = 1'b0;
      step; step; step;
      checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd8 || wb_data !== 32'd4 || resp_err !== 1'b1) begin errors++; $display("FAIL perr_later got v%b rd%0d d%0d err%b exp 1 8 4 1", wb_valid, wb_rd, wb_data, resp_err); end
      step;
   endtask

   task test_reset_midstream;
      issue_hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(8'h01, 5'(20 + i), 32'd1, 32'd1, 1'b0, 32'd0);
         step;
      end
      in_valid = 1'b0;
      issue_hold = 1'b0;
      step;
      issue_hold = 1'b1;
      step;
      checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL rstm_pre count %0d exp 3", fifo_count); end
      #2 rst = 1'b1;
      #1;
      checks++; if (fifo_count !== 3'd0 || {core_valid_instruction, wb_valid, exc_valid, resp_err} !== 4'b0000) begin
         errors++; $display("FAIL rstm_clear count %0d strobes %b exp 0 0000", fifo_count, {core_valid_instruction, wb_valid, exc_valid, resp_err});
      end
      checks++; if ({core_opcode, core_operand_a, wb_rd} !== '0) begin errors++; $display("FAIL rstm_data got %h exp 0", {core_opcode, core_operand_a, wb_rd}); end
      step;
      rst = 1'b0;
      issue_hold = 1'b0;
      for (int c = 0; c < 6; c++) begin
         step;
         checks++; if ({wb_valid, core_valid_instruction, resp_err} !== 3'b000 || fifo_count !== 3'd0) begin
            errors++; $display("FAIL rstm_after%0d strobes %b count %0d exp 000 0", c, {wb_valid, core_valid_instruction, resp_err}, fifo_count);
         end
      end
   endtask

   initial begin
      rst = 1'b1; suppress = 1'b0; issue_hold = 1'b0;
      in_valid = 1'b0; in_opcode = '0; in_rd = '0;
      in_rs1_val = '0; in_rs2_val = '0; in_use_imm = 1'b0; in_imm = '0;
      test_reset;
      test_single_add;
      test_back_to_back;
      step; step;
      test_full_hold;
      step; step;
      test_exceptions;
      test_protocol_err;
      test_reset_midstream;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
